i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h42, the 7-bit address this device responds to.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port scl_in, input, 1, bus SCL level (asynchronous to clk).
REQ-005 SHALL have port sda_in, input, 1, bus SDA level (asynchronous to clk).
REQ-006 SHALL have port sda_oe, output, 1; 1 = pull SDA low, 0 = release.
REQ-007 SHALL have port rx_data, output, 8, last byte received in a write transfer.
REQ-008 SHALL have port rx_valid, output, 1, one-clk pulse when rx_data updates.
REQ-009 SHALL have port tx_data, input, 8, byte to send in a read transfer; sampled when tx_req pulses.
REQ-010 SHALL have port tx_req, output, 1, one-clk pulse when the next read byte is loaded.
REQ-011 SHALL have port busy, output, 1, high from START to STOP.
REQ-012 SHALL have port addressed, output, 1, high from address ACK until the next START or STOP.

Function
REQ-013 SHALL pass scl_in and sda_in through a 2-flop synchronizer, then a registered edge detector; clk SHALL be at least 16x the SCL rate.
REQ-014 SHALL detect START as a synchronized SDA fall while synchronized SCL is high, and STOP as an SDA rise while SCL is high.
REQ-015 SHALL sample data bits on synchronized SCL rising edges, MSB first.
REQ-016 SHALL change sda_oe only on the clk edge following a detected synchronized SCL falling edge, except on STOP, START and reset.
REQ-017 SHALL implement the states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
REQ-018 IDLE -> ADDR on START, with busy=1 and the bit counter cleared.
REQ-019 ADDR SHALL shift in 8 bits; on the 8th sample it compares bits[7:1] with SLAVE_ADDR.
- Match: go to ADDR_ACK.
- Mismatch: go to IDLE with sda_oe=0 and busy held until STOP.
REQ-020 ADDR_ACK SHALL drive sda_oe=1 from the 8th SCL fall to the 9th SCL fall and set addressed=1.
- R/W=0: next state WR_BYTE.
- R/W=1: pulse tx_req at the 8th SCL fall, latch tx_data, next state RD_BYTE.
REQ-021 WR_BYTE SHALL shift 8 bits; on the 8th sample it updates rx_data and pulses rx_valid for exactly one clk, then goes to WR_ACK.
REQ-022 WR_ACK SHALL always ACK (sda_oe=1 for the 9th clock), then return to WR_BYTE.
REQ-023 RD_BYTE SHALL drive sda_oe=~bit from each SCL fall, MSB first; after the 8th bit's SCL fall it SHALL release SDA and go to RD_ACK.
REQ-024 RD_ACK SHALL sample SDA on the 9th SCL rise.
- 0 (ACK): pulse tx_req, latch tx_data, next state RD_BYTE.
- 1 (NACK): go to IDLE with sda_oe=0.
REQ-025 STOP in any state SHALL force IDLE with sda_oe=0, busy=0 and addressed=0 on the next clk.
REQ-026 START in any non-IDLE state (repeated START) SHALL force ADDR with sda_oe=0 and addressed=0.
REQ-027 A START or STOP on the same clk as a data-bit event SHALL take priority over that event.
REQ-028 The 4-bit bit counter SHALL count 0..8 and clear on each byte boundary; it SHALL never wrap.

Reset
REQ-029 Reset SHALL asynchronously set:
- state=IDLE; sda_oe, rx_valid, tx_req, busy, addressed = 0; rx_data = 8'h00.
- Synchronizer and edge-detect flops to 1 (idle bus high), so that deasserting reset on a high bus creates no false START.
REQ-030 Reset asserted mid-transfer SHALL release SDA immediately, and the block SHALL wait for a new START.

Structure
REQ-031 State encodings, ACK=1'b0/NACK=1'b1 constants and the 7-bit address width SHALL live in a shared i2c_defs include shared with the master.
REQ-032 The synchronizer plus edge detector SHALL be the sub-module i2c_sync_edge (outputs level, rise, fall), instantiated once for SCL and once for SDA.

Verification
REQ-033 Write 0x84 (addr 0x42,W), data 0xA5, STOP -> sda_oe=1 on both ACK clocks, one rx_valid with rx_data=8'hA5, busy=0 after STOP.
REQ-034 Read 0x85, tx_data=8'h3C, master NACK -> tx_req pulses once, SDA carries 0,0,1,1,1,1,0,0, then IDLE with sda_oe=0.
REQ-035 Address 0x90 (mismatch) -> sda_oe stays 0 for the whole transfer, addressed=0, no rx_valid.
REQ-036 Write one byte, then repeated START, then read addr 0x85 with ACK/ACK/NACK -> three tx_req pulses, addressed re-asserted after the second address ACK.
REQ-037 Reset asserted during RD_BYTE while sda_oe=1 -> sda_oe=0 within the same cycle; after release, no activity until a new START.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels and address width.
package i2c_slave_pkg;

    localparam int unsigned AddrWidth = 7;

    localparam logic Ack  = 1'b0;
    localparam logic Nack = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdAck
    } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer followed by a registered edge detector for one I2C bus line.
module i2c_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle-high bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave: 7-bit address match, always-ACK byte writes, byte reads fed by a tx_req handshake.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [AddrWidth-1:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       addressed
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk_i   (clk),
        .rst_i   (reset),
        .d_i     (scl_in),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk_i   (clk),
        .rst_i   (reset),
        .d_i     (sda_in),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic start_det;
    logic stop_det;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_e     state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       rw_q;
    logic       sda_oe_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       tx_req_q;
    logic       busy_q;
    logic       addressed_q;

    // In the ACK states bit_cnt_q doubles as the phase: 8 = ACK not yet driven, 0 = driving.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            if (tx_req_q) begin
                shift_q <= tx_data;
            end
            if (stop_det) begin
                state_q     <= StIdle;
                bit_cnt_q   <= 4'd0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
                addressed_q <= 1'b0;
            end else if (start_det) begin
                state_q     <= StAddr;
                bit_cnt_q   <= 4'd0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b1;
                addressed_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_lvl};
                            if (bit_cnt_q == 4'd7) begin
                                rw_q <= sda_lvl;
                                if (shift_q[6:0] == SLAVE_ADDR) begin
                                    state_q   <= StAddrAck;
                                    bit_cnt_q <= 4'd8;
                                end else begin
                                    state_q   <= StIdle;
                                    bit_cnt_q <= 4'd0;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q    <= 1'b1;
                                addressed_q <= 1'b1;
                                bit_cnt_q   <= 4'd0;
                                tx_req_q    <= rw_q;
                            end else if (rw_q) begin
                                state_q   <= StRdByte;
                                sda_oe_q  <= ~shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= 4'd1;
                            end else begin
                                state_q  <= StWrByte;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    StWrByte: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_lvl};
                            if (bit_cnt_q == 4'd7) begin
                                rx_data_q  <= {shift_q[6:0], sda_lvl};
                                rx_valid_q <= 1'b1;
                                state_q    <= StWrAck;
                                bit_cnt_q  <= 4'd8;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StWrAck: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b1;
                                bit_cnt_q <= 4'd0;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StWrByte;
                            end
                        end
                    end
                    StRdByte: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b0;
                                state_q   <= StRdAck;
                                bit_cnt_q <= 4'd0;
                            end else begin
                                sda_oe_q  <= ~shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StRdAck: begin
                        if (scl_rise) begin
                            if (sda_lvl == Ack) begin
                                tx_req_q  <= 1'b1;
                                state_q   <= StRdByte;
                                bit_cnt_q <= 4'd0;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StIdle;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign busy      = busy_q;
    assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level I2C master drives the bus; results are checked against a
// transaction-level model of what the slave should ACK, return and report.
module tb_i2c_slave;

    localparam int T = 8;
    localparam logic [6:0] MyAddr = 7'h42;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_req, busy, addressed;
    logic [7:0] rx_data;
    logic       sda_line;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(MyAddr)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .busy      (busy),
        .addressed (addressed)
    );

    int n_cmp = 0;
    int n_err = 0;
    int rxv_cnt = 0;
    int txr_cnt = 0;
    int oe_cnt = 0;
    int oe_bad = 0;
    logic oe_prev = 1'b0;
    logic [7:0] rx_log[$];
    logic [7:0] data_q[4];

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                rxv_cnt++;
                rx_log.push_back(rx_data);
            end
            if (tx_req) txr_cnt++;
            if (sda_oe) oe_cnt++;
            if (sda_oe != oe_prev && scl_m) oe_bad++;
        end
        oe_prev = sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(2 * T);
        scl_m = 1'b0;
        wait_clk(T);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T);
        b = sda_line;
        wait_clk(T);
        scl_m = 1'b0;
        wait_clk(T);
    endtask

    task automatic send_start();
        sda_m = 1'b1;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(2 * T);
        sda_m = 1'b0;
        wait_clk(2 * T);
        scl_m = 1'b0;
        wait_clk(T);
    endtask

    task automatic send_stop();
        sda_m = 1'b0;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(2 * T);
        sda_m = 1'b1;
        wait_clk(2 * T);
    endtask

    // One addressed transfer (no STOP); n bytes from data_q are written or expected back.
    task automatic do_xfer(input logic [6:0] addr, input logic rw, input int n);
        logic       match;
        logic [7:0] abyte;
        logic [7:0] got;
        logic       b;
        int         rx0, tx0, oe0, rxb;
        match = (addr == MyAddr);
        abyte = {addr, rw};
        rx0 = rxv_cnt;
        tx0 = txr_cnt;
        oe0 = oe_cnt;
        rxb = rx_log.size();
        if (rw) tx_data = data_q[0];
        send_start();
        check("start_busy", busy, 1);
        check("start_addressed", addressed, 0);
        for (int i = 7; i >= 0; i--) write_bit(abyte[i]);
        read_bit(b);
        check("addr_ack", b, match ? 0 : 1);
        for (int k = 0; k < n; k++) begin
            if (!rw) begin
                for (int i = 7; i >= 0; i--) write_bit(data_q[k][i]);
                read_bit(b);
                check("wr_ack", b, match ? 0 : 1);
            end else begin
                for (int i = 7; i >= 0; i--) begin
                    read_bit(b);
                    got[i] = b;
                end
                check("rd_byte", got, match ? data_q[k] : 8'hFF);
                if (k + 1 < n) tx_data = data_q[k + 1];
                write_bit(k == n - 1);
            end
        end
        check("addressed", addressed, match);
        check("busy_mid", busy, 1);
        check("rx_count", rxv_cnt - rx0, (match && !rw) ? n : 0);
        check("tx_req_count", txr_cnt - tx0, (match && rw) ? n : 0);
        if (match && !rw && rx_log.size() >= rxb + n) begin
            for (int k = 0; k < n; k++) check("rx_data", rx_log[rxb + k], data_q[k]);
        end
        if (!match) check("oe_quiet", oe_cnt - oe0, 0);
        if (match && rw) check("oe_after_nack", sda_oe, 0);
    endtask

    task automatic end_xfer();
        send_stop();
        wait_clk(4);
        check("stop_busy", busy, 0);
        check("stop_addressed", addressed, 0);
        check("stop_oe", sda_oe, 0);
    endtask

    initial begin
        logic       b;
        logic       rw;
        logic [6:0] addr;
        int         n, rx0, tx0, oe0;

        wait_clk(3);
        check("rst_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_addressed", addressed, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_rx_data", rx_data, 8'h00);
        reset = 1'b0;
        wait_clk(5);
        check("idle_busy", busy, 0);

        data_q[0] = 8'hA5;
        do_xfer(MyAddr, 1'b0, 1);
        end_xfer();

        data_q[0] = 8'h3C;
        do_xfer(MyAddr, 1'b1, 1);
        end_xfer();

        data_q[0] = 8'($urandom);
        do_xfer(7'h48, 1'b0, 1);
        end_xfer();

        data_q[0] = 8'h5A;
        do_xfer(MyAddr, 1'b0, 1);
        data_q[0] = 8'h11;
        data_q[1] = 8'h22;
        data_q[2] = 8'h33;
        do_xfer(MyAddr, 1'b1, 3);
        end_xfer();

        for (int t = 0; t < 12; t++) begin
            addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : MyAddr;
            rw   = 1'($urandom);
            n    = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) data_q[k] = 8'($urandom);
            do_xfer(addr, rw, n);
            end_xfer();
        end

        // Reset in the middle of a read byte whose bits all pull SDA low.
        tx_data = 8'h00;
        send_start();
        for (int i = 7; i >= 0; i--) write_bit(((8'h85 >> i) & 8'h01) != 0);
        read_bit(b);
        check("rst_test_ack", b, 0);
        check("rd_drive", sda_oe, 1);
        reset = 1'b1;
        #1;
        check("reset_release", sda_oe, 0);
        check("reset_busy", busy, 0);
        wait_clk(3);
        reset = 1'b0;
        rx0 = rxv_cnt;
        tx0 = txr_cnt;
        oe0 = oe_cnt;
        sda_m = 1'b1;
        for (int i = 0; i < 9; i++) write_bit(1'($urandom));
        check("post_rst_busy", busy, 0);
        check("post_rst_addressed", addressed, 0);
        check("post_rst_oe", oe_cnt - oe0, 0);
        check("post_rst_tx", txr_cnt - tx0, 0);
        check("post_rst_rx", rxv_cnt - rx0, 0);

        data_q[0] = 8'hC3;
        do_xfer(MyAddr, 1'b0, 1);
        end_xfer();

        check("oe_changes_scl_high", oe_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
